dragon_swarm_move: RTL and testbench
====================================

DRAGON_SWARM_MOVE -- requirements
Module: dragon_swarm_move

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- N_DRAGONS, 4: number of independent dragon channels.
- START_TLX, 680: spawn X in pixels.
- START_TLY, 60: spawn Y in pixels.
- X_SPEED, -120: X step in 1/64 pixel per frame.
- Y_SPEED, 70: Y step magnitude in 1/64 pixel per frame.
- Y_MIN, 20 / Y_MAX, 180: Y bounce bounds in pixels.
- EXIT_X, -50: X at or below which a dragon is retired.
- DYING_FRAMES, 16: frames spent in the DYING state.
- SPAWN_LO, 500 / SPAWN_HI, 605: spawn window, open range.
- FLIP_LO, 300 / FLIP_HI, 600: Y-flip window, open range.
- MIN_SPAWN_GAP, 30: minimum number of frames between spawns.
- LFSR_SEED, 16'hACE1: internal LFSR seed.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: the single clock.
- reset, in, 1: synchronous, active-high reset.
- startOfFrame, in, 1: one-cycle frame strobe.
- pause, in, 1: freezes all frame activity.
- RNG, in, 11: external random value.
- collision, in, N_DRAGONS: per-channel hit.
- topLeftX, out, N_DRAGONS x 11 signed: per-channel X in pixels.
- topLeftY, out, N_DRAGONS x 11 signed: per-channel Y in pixels.
- active, out, N_DRAGONS: channel is in the ACTIVE state.
- dying, out, N_DRAGONS: channel is in the DYING state.
- hitPulse, out, N_DRAGONS: one-cycle pulse on a hit.
- missPulse, out, N_DRAGONS: one-cycle pulse when a dragon exits the screen.

Function
REQ-003 Each channel SHALL hold signed 17-bit fixed-point X and Y with 6 fractional bits; the pixel outputs SHALL be the arithmetic right shift by 6.
REQ-004 Each channel SHALL implement the states IDLE, ACTIVE and DYING.
REQ-005 A frame event SHALL be a cycle with startOfFrame=1 and pause=0; all motion, spawning, LFSR stepping and dying countdown SHALL occur only on frame events.
REQ-006 The 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance once per frame event; the random value for channel i SHALL be R_i = (RNG + LFSR[10:0] + 97*i) mod 2048.
REQ-007 On a frame event, the lowest-index IDLE channel SHALL spawn when SPAWN_LO < R_0 < SPAWN_HI and the gap counter is >= MIN_SPAWN_GAP.
REQ-008 A spawned channel SHALL load START_TLX*64 and START_TLY*64, set its Y direction to +, go ACTIVE, and clear the gap counter.
REQ-009 At most one channel SHALL spawn per frame.
REQ-010 The gap counter SHALL increment on every frame event without a spawn and saturate at MIN_SPAWN_GAP.
REQ-011 On a frame event, an ACTIVE channel SHALL pick its Y direction from its current pixel Y, in priority order:
- Y < Y_MIN: direction is +.
- else Y > Y_MAX: direction is -.
- else FLIP_LO < R_i < FLIP_HI: direction toggles.
- otherwise: direction holds.
REQ-012 In that same frame event, the ACTIVE channel SHALL apply X += X_SPEED and Y += dir*Y_SPEED using the new direction (no one-frame lag).
REQ-013 On a frame event where an ACTIVE channel's current pixel X <= EXIT_X, the channel SHALL instead go IDLE without moving and pulse missPulse[i] for one cycle.
REQ-014 collision[i] SHALL be sampled every cycle.
REQ-015 If collision[i] is high while channel i is ACTIVE, the channel SHALL go DYING at the next edge, freeze its position, load the dying counter with DYING_FRAMES, and pulse hitPulse[i] for one cycle.
REQ-016 collision[i] SHALL be ignored while channel i is IDLE or DYING.
REQ-017 If collision and a frame event occur in the same cycle, the collision SHALL win: no motion and no exit check for that channel.
REQ-018 A DYING channel SHALL decrement its counter on each frame event and go IDLE when the counter reaches 0.
REQ-019 An IDLE channel SHALL hold position START_TLX/START_TLY with active=0 and dying=0.
REQ-020 While pause=1, the block SHALL freeze all state except collision-to-DYING transitions.
REQ-021 All outputs SHALL be registered, with a one-cycle latency from the triggering edge.

Reset
REQ-022 On reset, every channel SHALL return to IDLE at START_TLX/START_TLY with Y direction +.
REQ-023 On reset, active, dying, hitPulse and missPulse SHALL all be 0.
REQ-024 On reset, the LFSR SHALL load LFSR_SEED, the gap counter SHALL load MIN_SPAWN_GAP, and the dying counters SHALL load 0.
REQ-025 Reset SHALL override all other inputs in the same cycle, including when asserted mid-flight or mid-dying.

Structure
REQ-026 The package dragon_pkg SHALL hold:
- the state enum (IDLE/ACTIVE/DYING);
- FP_SHIFT=6 and FP_WIDTH=17;
- PIX_WIDTH=11;
- the LFSR tap constant.
REQ-027 Per-channel logic SHALL be a sub-module dragon_channel, instantiated N_DRAGONS times by generate.
REQ-028 The spawn arbiter, gap counter and LFSR SHALL reside in the top level.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Reset, then idle frames with RNG such that R_0 is outside the spawn window: all active=0, all topLeftX=680, all topLeftY=60.
- Force R_0=550 on one frame: only channel 0 goes active; the next qualifying frame within 30 frames spawns nothing; after the gap elapses, channel 1 spawns.
- Channel 0 active, then one frame with R_0 outside the flip window: topLeftX=678 (43400>>>6).
- Channel 0 free-running with no flips: missPulse[0] one cycle after frame 390 post-spawn (X crosses -50 at frame 389), then IDLE.
- collision[0] coincident with startOfFrame: position unchanged, hitPulse[0]=1 for one cycle, dying[0]=1 for 16 frames, then IDLE; a collision during DYING has no effect.
- pause=1 across 20 strobes: positions, LFSR and dying counter unchanged; collision still forces DYING; reset mid-DYING gives all-IDLE on the next cycle.

Source files
------------

// File: rtl/dragon_pkg.sv
// ============================================================================
// Module      : dragon_pkg
// Description : Shared types and constants for the dragon swarm mover.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dragon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DYING  = 2'd2
  } dragon_state_t;

  localparam int FP_SHIFT  = 6;
  localparam int FP_WIDTH  = 17;
  localparam int PIX_WIDTH = 11;

  // Fibonacci taps 16,14,13,11 expressed as register bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/dragon_channel.sv
// ============================================================================
// Module      : dragon_channel
// Description : One dragon: fixed-point motion, Y bounce, exit and dying.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dragon_channel
  import dragon_pkg::*;
#(
  parameter int START_TLX    = 680,
  parameter int START_TLY    = 60,
  parameter int X_SPEED      = -120,
  parameter int Y_SPEED      = 70,
  parameter int Y_MIN        = 20,
  parameter int Y_MAX        = 180,
  parameter int EXIT_X       = -50,
  parameter int DYING_FRAMES = 16,
  parameter int FLIP_LO      = 300,
  parameter int FLIP_HI      = 600
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame,
  input  logic                 spawn,
  input  logic [PIX_WIDTH-1:0] rnd,
  input  logic                 collision,
  output logic                 idle,
  output logic [PIX_WIDTH-1:0] topLeftX,
  output logic [PIX_WIDTH-1:0] topLeftY,
  output logic                 active,
  output logic                 dying,
  output logic                 hitPulse,
  output logic                 missPulse
);

  localparam int CNT_W = $clog2(DYING_FRAMES + 2);

  localparam logic signed [FP_WIDTH-1:0]  c_start_x = FP_WIDTH'(START_TLX * (2 ** FP_SHIFT));
  localparam logic signed [FP_WIDTH-1:0]  c_start_y = FP_WIDTH'(START_TLY * (2 ** FP_SHIFT));
  localparam logic signed [FP_WIDTH-1:0]  c_x_step  = FP_WIDTH'(X_SPEED);
  localparam logic signed [FP_WIDTH-1:0]  c_y_step  = FP_WIDTH'(Y_SPEED);
  localparam logic signed [PIX_WIDTH-1:0] c_y_min   = PIX_WIDTH'(Y_MIN);
  localparam logic signed [PIX_WIDTH-1:0] c_y_max   = PIX_WIDTH'(Y_MAX);
  localparam logic signed [PIX_WIDTH-1:0] c_exit_x  = PIX_WIDTH'(EXIT_X);
  localparam logic [PIX_WIDTH-1:0]        c_flip_lo = PIX_WIDTH'(FLIP_LO);
  localparam logic [PIX_WIDTH-1:0]        c_flip_hi = PIX_WIDTH'(FLIP_HI);
  localparam logic [CNT_W-1:0]            c_dying   = CNT_W'(DYING_FRAMES);

  dragon_state_t                 r_state, w_state_nxt;
  logic signed [FP_WIDTH-1:0]    r_x, r_y, w_x_nxt, w_y_nxt;
  logic                          r_dir, w_dir_nxt, w_dir_mv;
  logic [CNT_W-1:0]              r_cnt, w_cnt_nxt;
  logic                          w_hit, w_miss, w_flip;
  logic signed [PIX_WIDTH-1:0]   w_px, w_py;

  assign w_px     = r_x[FP_WIDTH-1:FP_SHIFT];
  assign w_py     = r_y[FP_WIDTH-1:FP_SHIFT];
  assign w_flip   = (rnd > c_flip_lo) && (rnd < c_flip_hi);
  assign idle     = (r_state == IDLE);
  assign topLeftX = r_x[FP_WIDTH-1:FP_SHIFT];
  assign topLeftY = r_y[FP_WIDTH-1:FP_SHIFT];

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_dir_nxt   = r_dir;
    w_dir_mv    = r_dir;
    w_cnt_nxt   = r_cnt;
    w_hit       = 1'b0;
    w_miss      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (spawn) begin
          w_state_nxt = ACTIVE;
          w_x_nxt     = c_start_x;
          w_y_nxt     = c_start_y;
          w_dir_nxt   = 1'b1;
        end
      end
      ACTIVE: begin
        // A hit takes precedence over any frame motion in the same cycle
        if (collision) begin
          w_state_nxt = DYING;
          w_cnt_nxt   = c_dying;
          w_hit       = 1'b1;
        end else if (frame) begin
          if (w_px <= c_exit_x) begin
            w_state_nxt = IDLE;
            w_x_nxt     = c_start_x;
            w_y_nxt     = c_start_y;
            w_miss      = 1'b1;
          end else begin
            if (w_py < c_y_min)      w_dir_mv = 1'b1;
            else if (w_py > c_y_max) w_dir_mv = 1'b0;
            else if (w_flip)         w_dir_mv = ~r_dir;
            w_dir_nxt = w_dir_mv;
            w_x_nxt   = r_x + c_x_step;
            w_y_nxt   = w_dir_mv ? (r_y + c_y_step) : (r_y - c_y_step);
          end
        end
      end
      DYING: begin
        if (frame) begin
          if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_x_nxt     = c_start_x;
            w_y_nxt     = c_start_y;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_x       <= c_start_x;
      r_y       <= c_start_y;
      r_dir     <= 1'b1;
      r_cnt     <= '0;
      active    <= 1'b0;
      dying     <= 1'b0;
      hitPulse  <= 1'b0;
      missPulse <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_dir     <= w_dir_nxt;
      r_cnt     <= w_cnt_nxt;
      active    <= (w_state_nxt == ACTIVE);
      dying     <= (w_state_nxt == DYING);
      hitPulse  <= w_hit;
      missPulse <= w_miss;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dragon_swarm_move.sv
// ============================================================================
// Module      : dragon_swarm_move
// Description : Swarm of dragon channels with shared LFSR, spawn gap and arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dragon_swarm_move
  import dragon_pkg::*;
#(
  parameter int          N_DRAGONS     = 4,
  parameter int          START_TLX     = 680,
  parameter int          START_TLY     = 60,
  parameter int          X_SPEED       = -120,
  parameter int          Y_SPEED       = 70,
  parameter int          Y_MIN         = 20,
  parameter int          Y_MAX         = 180,
  parameter int          EXIT_X        = -50,
  parameter int          DYING_FRAMES  = 16,
  parameter int          SPAWN_LO      = 500,
  parameter int          SPAWN_HI      = 605,
  parameter int          FLIP_LO       = 300,
  parameter int          FLIP_HI       = 600,
  parameter int          MIN_SPAWN_GAP = 30,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 startOfFrame,
  input  logic                                 pause,
  input  logic [PIX_WIDTH-1:0]                 RNG,
  input  logic [N_DRAGONS-1:0]                 collision,
  output logic [N_DRAGONS-1:0][PIX_WIDTH-1:0]  topLeftX,
  output logic [N_DRAGONS-1:0][PIX_WIDTH-1:0]  topLeftY,
  output logic [N_DRAGONS-1:0]                 active,
  output logic [N_DRAGONS-1:0]                 dying,
  output logic [N_DRAGONS-1:0]                 hitPulse,
  output logic [N_DRAGONS-1:0]                 missPulse
);

  localparam int GAP_W = $clog2(MIN_SPAWN_GAP + 2);

  localparam logic [GAP_W-1:0]     c_gap_max  = GAP_W'(MIN_SPAWN_GAP);
  localparam logic [PIX_WIDTH-1:0] c_spawn_lo = PIX_WIDTH'(SPAWN_LO);
  localparam logic [PIX_WIDTH-1:0] c_spawn_hi = PIX_WIDTH'(SPAWN_HI);

  logic                                w_frame, w_spawn_ok;
  logic [15:0]                         r_lfsr;
  logic [GAP_W-1:0]                    r_gap;
  logic [N_DRAGONS-1:0][PIX_WIDTH-1:0] w_rnd;
  logic [N_DRAGONS-1:0]                w_idle, w_cand, w_spawn;

  assign w_frame    = startOfFrame & ~pause;
  assign w_spawn_ok = w_frame && (w_rnd[0] > c_spawn_lo) && (w_rnd[0] < c_spawn_hi)
                      && (r_gap >= c_gap_max);
  assign w_cand     = w_idle & {N_DRAGONS{w_spawn_ok}};
  // Isolate the lowest set bit so only the lowest-index idle channel spawns
  assign w_spawn    = w_cand & (~w_cand + N_DRAGONS'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
      r_gap  <= c_gap_max;
    end else if (w_frame) begin
      r_lfsr <= lfsr_next(r_lfsr);
      if (|w_spawn)
        r_gap <= '0;
      else if (r_gap < c_gap_max)
        r_gap <= r_gap + GAP_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < N_DRAGONS; gi++) begin : g_chan
      assign w_rnd[gi] = RNG + r_lfsr[PIX_WIDTH-1:0] + PIX_WIDTH'(97 * gi);

      dragon_channel #(
        .START_TLX    (START_TLX),
        .START_TLY    (START_TLY),
        .X_SPEED      (X_SPEED),
        .Y_SPEED      (Y_SPEED),
        .Y_MIN        (Y_MIN),
        .Y_MAX        (Y_MAX),
        .EXIT_X       (EXIT_X),
        .DYING_FRAMES (DYING_FRAMES),
        .FLIP_LO      (FLIP_LO),
        .FLIP_HI      (FLIP_HI)
      ) u_chan (
        .clk       (clk),
        .reset     (reset),
        .frame     (w_frame),
        .spawn     (w_spawn[gi]),
        .rnd       (w_rnd[gi]),
        .collision (collision[gi]),
        .idle      (w_idle[gi]),
        .topLeftX  (topLeftX[gi]),
        .topLeftY  (topLeftY[gi]),
        .active    (active[gi]),
        .dying     (dying[gi]),
        .hitPulse  (hitPulse[gi]),
        .missPulse (missPulse[gi])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_dragon_swarm_move.sv
// ============================================================================
// Module      : tb_dragon_swarm_move
// Description : Self-checking bench for dragon_swarm_move with reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dragon_swarm_move;

  localparam int N  = 4;
  localparam int SX = 680;
  localparam int SY = 60;

  logic                 clk = 1'b0;
  logic                 reset, startOfFrame, pause;
  logic [10:0]          RNG;
  logic [N-1:0]         collision;
  logic [N-1:0][10:0]   topLeftX, topLeftY;
  logic [N-1:0]         active, dying, hitPulse, missPulse;

  always #5 clk = ~clk;

  dragon_swarm_move #(.N_DRAGONS(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .pause        (pause),
    .RNG          (RNG),
    .collision    (collision),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .active       (active),
    .dying        (dying),
    .hitPulse     (hitPulse),
    .missPulse    (missPulse)
  );

  // Reference model: 0 idle, 1 flying, 2 dying; positions in 1/64 pixel
  int m_state[N], m_x[N], m_y[N], m_dir[N], m_cnt[N];
  bit m_hit[N], m_miss[N];
  int m_lfsr, m_gap;
  int n_pass = 0, n_total = 0;

  typedef struct { int r0; logic [N-1:0] exp_act; } vec_t;
  vec_t tbl[7];

  task automatic check_int(string name, int got, int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic check_vec(string name, logic [127:0] got, logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i] = 0; m_x[i] = SX * 64; m_y[i] = SY * 64; m_dir[i] = 1;
      m_cnt[i] = 0; m_hit[i] = 0; m_miss[i] = 0;
    end
    m_lfsr = 'hACE1;
    m_gap  = 30;
  endtask

  task automatic model_step(bit rst, bit sof, bit pse, int rng, logic [N-1:0] col);
    bit frame;
    int sp, r0, ri, fb;
    if (rst) begin
      model_reset();
      return;
    end
    frame = sof && !pse;
    sp = -1;
    r0 = (rng + (m_lfsr % 2048)) % 2048;
    if (frame && r0 > 500 && r0 < 605 && m_gap >= 30)
      for (int i = 0; i < N; i++) if (sp < 0 && m_state[i] == 0) sp = i;
    for (int i = 0; i < N; i++) begin
      m_hit[i] = 0; m_miss[i] = 0;
      if (m_state[i] == 0) begin
        if (i == sp) begin
          m_state[i] = 1; m_x[i] = SX * 64; m_y[i] = SY * 64; m_dir[i] = 1;
        end
      end else if (m_state[i] == 1) begin
        if (col[i]) begin
          m_state[i] = 2; m_cnt[i] = 16; m_hit[i] = 1;
        end else if (frame) begin
          if ((m_x[i] >>> 6) <= -50) begin
            m_state[i] = 0; m_x[i] = SX * 64; m_y[i] = SY * 64; m_miss[i] = 1;
          end else begin
            ri = (rng + (m_lfsr % 2048) + 97 * i) % 2048;
            if ((m_y[i] >>> 6) < 20)       m_dir[i] = 1;
            else if ((m_y[i] >>> 6) > 180) m_dir[i] = -1;
            else if (ri > 300 && ri < 600) m_dir[i] = -m_dir[i];
            m_x[i] = m_x[i] - 120;
            m_y[i] = m_y[i] + m_dir[i] * 70;
          end
        end
      end else if (frame) begin
        m_cnt[i] = m_cnt[i] - 1;
        if (m_cnt[i] == 0) begin
          m_state[i] = 0; m_x[i] = SX * 64; m_y[i] = SY * 64;
        end
      end
    end
    if (frame) begin
      if (sp >= 0) m_gap = 0;
      else if (m_gap < 30) m_gap++;
      fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
      m_lfsr = ((m_lfsr << 1) | fb) & 'hFFFF;
    end
  endtask

  task automatic compare_model();
    logic [N-1:0][10:0] ex, ey;
    logic [N-1:0]       ea, ed, eh, em;
    for (int i = 0; i < N; i++) begin
      ex[i] = 11'(m_x[i] >>> 6);
      ey[i] = 11'(m_y[i] >>> 6);
      ea[i] = (m_state[i] == 1);
      ed[i] = (m_state[i] == 2);
      eh[i] = m_hit[i];
      em[i] = m_miss[i];
    end
    check_vec("model_cmp", 128'({topLeftX, topLeftY, active, dying, hitPulse, missPulse}),
              128'({ex, ey, ea, ed, eh, em}));
  endtask

  task automatic cycle(bit rst, bit sof, bit pse, logic [10:0] rng, logic [N-1:0] col);
    reset = rst; startOfFrame = sof; pause = pse; RNG = rng; collision = col;
    @(posedge clk);
    model_step(rst, sof, pse, int'(rng), col);
    #1;
    compare_model();
  endtask

  function automatic logic [10:0] rng_for(int r0);
    return 11'((r0 - (m_lfsr % 2048) + 2048) % 2048);
  endfunction

  task automatic frame_r0(int r0, logic [N-1:0] col);
    cycle(1'b0, 1'b1, 1'b0, rng_for(r0), col);
  endtask

  task automatic quiet();
    cycle(1'b0, 1'b0, 1'b0, 11'($urandom), '0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 11'd0, '0);
  endtask

  int x0, x1;

  initial begin
    tbl[0] = '{500,  4'b0000};
    tbl[1] = '{501,  4'b0001};
    tbl[2] = '{550,  4'b0001};
    tbl[3] = '{604,  4'b0001};
    tbl[4] = '{605,  4'b0000};
    tbl[5] = '{0,    4'b0000};
    tbl[6] = '{2047, 4'b0000};

    reset = 1'b1; startOfFrame = 1'b0; pause = 1'b0; RNG = '0; collision = '0;
    model_reset();
    do_reset();
    do_reset();
    for (int i = 0; i < N; i++) begin
      check_int($sformatf("reset_x%0d", i), int'($signed(topLeftX[i])), SX);
      check_int($sformatf("reset_y%0d", i), int'($signed(topLeftY[i])), SY);
    end
    check_int("reset_flags", int'({active, dying, hitPulse, missPulse}), 0);

    // Idle frames with R_0 outside the spawn window
    for (int f = 0; f < 10; f++) begin
      frame_r0(100 + f * 30, '0);
      quiet();
    end
    check_int("idle_active", int'(active), 0);
    check_int("idle_x0", int'($signed(topLeftX[0])), SX);
    check_int("idle_y3", int'($signed(topLeftY[3])), SY);

    // Spawn window boundaries, one frame after reset each
    foreach (tbl[k]) begin
      do_reset();
      frame_r0(tbl[k].r0, '0);
      check_int($sformatf("spawn_win_r0_%0d", tbl[k].r0), int'(active), int'(tbl[k].exp_act));
    end

    // Spawn, first move, gap enforcement, second spawn
    do_reset();
    frame_r0(550, '0);
    check_int("spawn_ch0_only", int'(active), 1);
    quiet();
    frame_r0(100, '0);
    check_int("first_move_x", int'($signed(topLeftX[0])), 678);
    check_int("first_move_y", int'($signed(topLeftY[0])), 61);
    for (int f = 2; f <= 30; f++) begin
      quiet();
      frame_r0(550, '0);
    end
    check_int("gap_blocks_spawn", int'(active), 1);
    quiet();
    frame_r0(550, '0);
    check_int("gap_elapsed_ch1", int'(active), 3);

    // Collision on channel 0, then pause behaviour
    quiet();
    x0 = int'($signed(topLeftX[0]));
    cycle(1'b0, 1'b0, 1'b0, 11'd0, 4'b0001);
    check_int("hit_pulse", int'(hitPulse), 1);
    check_int("hit_dying", int'(dying), 1);
    quiet();
    check_int("hit_pulse_drop", int'(hitPulse), 0);
    frame_r0(100, 4'b0001);
    check_int("dying_ignores_col", int'(hitPulse), 0);
    quiet();
    frame_r0(100, '0);
    quiet();
    x1 = int'($signed(topLeftX[1]));
    for (int s = 0; s < 20; s++) begin
      cycle(1'b0, 1'b1, 1'b1, rng_for(550), (s == 10) ? 4'b0010 : 4'b0000);
      cycle(1'b0, 1'b0, 1'b1, 11'($urandom), '0);
    end
    check_int("pause_x0_frozen", int'($signed(topLeftX[0])), x0);
    check_int("pause_x1_frozen", int'($signed(topLeftX[1])), x1);
    check_int("pause_col_dying", int'(dying), 3);
    check_int("pause_no_spawn", int'(active), 0);
    for (int f = 0; f < 13; f++) begin
      frame_r0(100, '0);
      quiet();
    end
    check_int("dying0_after_15", int'(dying[0]), 1);
    frame_r0(100, '0);
    check_int("dying0_done", int'(dying[0]), 0);
    check_int("dying0_home_x", int'($signed(topLeftX[0])), SX);
    cycle(1'b1, 1'b1, 1'b0, 11'd0, 4'b1111);
    check_int("reset_mid_dying", int'({active, dying}), 0);
    check_int("reset_mid_dying_x1", int'($signed(topLeftX[1])), SX);

    // Free-running flight until the exit check retires channel 0
    frame_r0(550, '0);
    for (int f = 1; f <= 389; f++) begin
      quiet();
      frame_r0(100, '0);
    end
    check_int("exit_x_at_389", int'($signed(topLeftX[0])), -50);
    check_int("still_active_389", int'(active), 1);
    quiet();
    frame_r0(100, '0);
    check_int("miss_pulse", int'(missPulse), 1);
    check_int("miss_idle", int'(active), 0);
    check_int("miss_home_x", int'($signed(topLeftX[0])), SX);
    quiet();
    check_int("miss_pulse_drop", int'(missPulse), 0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] col;
      for (int i = 0; i < N; i++) col[i] = ($urandom % 40 == 0);
      cycle(($urandom % 700) == 0, ($urandom % 3) == 0, ($urandom % 6) == 0,
            11'($urandom), col);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

`default_nettype wire
